// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : constants shared by the pipelinecpu stages.  Rev 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [1:0]  PCSRC_PC4        = 2'b00;
    localparam logic [1:0]  PCSRC_BR         = 2'b01;
    localparam logic [1:0]  PCSRC_JR         = 2'b10;
    localparam logic [1:0]  PCSRC_J          = 2'b11;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Redirect targets are silently word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dffe32.sv
// ============================================================================
// dffe32 : 32-bit enabled register with async active-low reset value.  Rev 1.0
// ============================================================================
`default_nettype none

module dffe32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [31:0] rst_val_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= rst_val_i;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_if_stage.sv
// ============================================================================
// pipe_if_stage : PC, next-PC select and IF/ID register of pipelinecpu.  Rev 1.0
// ============================================================================
`default_nettype none

module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wpcir,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] dinst,
    output logic        dvalid
);

    logic [31:0] pc_q;
    logic [31:0] pc4;
    logic [31:0] npc_raw;
    logic [31:0] npc_d;
    logic [31:0] dinst_d;
    logic        dvalid_d;
    logic        dvalid_q;

    assign pc4 = pc_q + 32'd4;

    always_comb begin
        npc_raw = pc4;
        unique case (pcsource)
            PCSRC_PC4: npc_raw = pc4;
            PCSRC_BR:  npc_raw = bpc;
            PCSRC_JR:  npc_raw = rpc;
            PCSRC_J:   npc_raw = jpc;
        endcase
    end

    assign npc_d = word_align(npc_raw);

    // The delay-slot word is captured even on a redirect; only flush kills it.
    assign dinst_d  = flush ? NOP : imem_inst;
    assign dvalid_d = ~flush;

    dffe32 u_pc (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .en_i      (wpcir),
        .rst_val_i (RESET_PC),
        .d_i       (npc_d),
        .q_o       (pc_q)
    );

    dffe32 u_dpc4 (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .en_i      (wpcir),
        .rst_val_i (32'h0000_0000),
        .d_i       (pc4),
        .q_o       (dpc4)
    );

    dffe32 u_dinst (
        .clk_i     (clock),
        .rst_ni    (resetn),
        .en_i      (wpcir),
        .rst_val_i (NOP),
        .d_i       (dinst_d),
        .q_o       (dinst)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dvalid_q <= 1'b0;
        end else if (wpcir) begin
            dvalid_q <= dvalid_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign dvalid    = dvalid_q;

endmodule

`default_nettype wire

// File: doc/pipe_if_stage.md
# pipe_if_stage

Instruction-fetch stage of the five-stage `pipelinecpu`. It holds the program counter, selects the next PC from the redirect sources resolved in ID, and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register, with stall and flush control from the hazard unit. It is the first stage after reset; its IF/ID outputs feed the decode stage directly.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0000: bubble word inserted into IF/ID (`sll $0,$0,0`).

Ports:
- `clock`  in  1  stage clock, rising-edge active.
- `resetn`  in  1  asynchronous, active-low reset.
- `wpcir`  in  1  1 = PC and IF/ID write enabled; 0 = stall, hold both.
- `pcsource`  in  2  next-PC select: 00 = pc+4, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`  in  32  branch target from ID.
- `rpc`  in  32  jr register target from ID.
- `jpc`  in  32  jump target from ID.
- `flush`  in  1  kill the word currently being fetched; IF/ID loads `NOP`.
- `imem_addr`  out  32  instruction-memory address; equals `pc`.
- `imem_inst`  in  32  instruction word; combinational read of `imem_addr`, valid in the same cycle.
- `pc`  out  32  current PC register.
- `dpc4`  out  32  IF/ID: pc+4 of the captured instruction.
- `dinst`  out  32  IF/ID: captured instruction.
- `dvalid`  out  1  IF/ID: 1 = real instruction, 0 = bubble.

## Operation
- `pc4 = pc + 4`, computed modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- Next PC: `npc` is the `pcsource` mux output, with bits [1:0] forced to 00. An unaligned target is silently aligned; no exception is raised.
- Rising edge with `wpcir`=1:
  - `pc` <= `npc`.
  - `dpc4` <= `pc4`.
  - If `flush`=0: `dinst` <= `imem_inst` and `dvalid` <= 1.
  - If `flush`=1: `dinst` <= `NOP` and `dvalid` <= 0.
- Rising edge with `wpcir`=0:
  - `pc`, `dpc4`, `dinst` and `dvalid` all hold.
  - `pcsource` and `flush` are ignored. The ID stage is stalled too, so it re-presents any redirect on the next enabled cycle.
- Redirect and fetch in the same cycle: the instruction fetched at the old `pc` is still captured unless `flush`=1. This implements the MIPS delay slot; the hazard unit asserts `flush` only for annulled slots.
- No internal FSM beyond reset/run. After reset release, the stage fetches every enabled cycle.

## Timing
- Reset (`resetn`=0, asynchronous, takes effect immediately):
  - `pc` = `RESET_PC`.
  - `dpc4` = 0.
  - `dinst` = `NOP`.
  - `dvalid` = 0.
  - `imem_addr` = `RESET_PC`.
- Reset release is synchronised outside this block. The first capture occurs on the first rising edge with `resetn`=1.
- Latency: an instruction at address A appears on `dinst` one cycle after `pc`=A, provided `wpcir`=1.
- Redirect latency: `pcsource`/target sampled at edge N; `pc` shows the target after edge N.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values at once. Pending redirects are lost.
- `imem_addr` is purely combinational from `pc`; there is no extra register.

## Structure
- Shared package `pipe_pkg`:
  - `PCSRC_PC4`, `PCSRC_BR`, `PCSRC_JR`, `PCSRC_J` (2-bit).
  - `NOP_INST`.
  - `RESET_PC_DEFAULT`.
  - The decode stage and hazard unit use the same constants.
- Sub-module `dffe32`: 32-bit register with enable and asynchronous active-low reset value input.
  - Instantiated for `pc`, `dpc4` and `dinst`.
  - `dvalid` is a 1-bit flop inline.
- The next-PC mux and adder are inline combinational logic in `pipe_if_stage`.

## Test plan
- Reset: hold `resetn`=0 with a running clock -> `pc`=0, `dinst`=0, `dvalid`=0. Release, with imem returning A+0x100 at address A -> after 3 edges, `pc`=0xC and `dinst`=0x108, `dpc4`=0xC.
- Stall: `wpcir`=0 for 2 cycles at `pc`=0x10 with `pcsource`=01 and `bpc`=0x40 -> `pc`, `dinst`, `dpc4` unchanged. Deassert -> `pc`=0x40 and `dinst`=word@0x10.
- Redirects: each `pcsource` value in turn, with `bpc`=0x80, `rpc`=0x123 and `jpc`=0x400 -> `pc` = 0x80, 0x120 (aligned), 0x400. Delay-slot word is captured with `dvalid`=1.
- Flush: `flush`=1 with `wpcir`=1 at `pc`=0x20 -> `dinst`=`NOP`, `dvalid`=0, `dpc4`=0x24. Same stimulus with `wpcir`=0 -> IF/ID holds its previous value.
- Wrap: force `pc`=0xFFFF_FFFC via `jpc` -> next `pc`=0x0000_0000, `dpc4`=0.
- Async reset mid-run: drop `resetn` between edges while `pcsource`=11 -> outputs reach reset values before the next edge; no jump is taken after release.
